// File: rtl/client_queue_pkg.sv
// rtl/client_queue_pkg.sv - shared types and constants for the client queue sequencer
package client_queue_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  localparam int DEF_MAX_CLIENTS = 7;
  localparam int DEF_SVC_TIME    = 5;

  // Smallest wait_time width that holds max_clients*svc_time without wrapping.
  function automatic int min_wt_bits(input int max_clients, input int svc_time);
    return $clog2(max_clients * svc_time + 1);
  endfunction

endpackage

// File: rtl/client_queue_ctrl_if.sv
// rtl/client_queue_ctrl_if.sv - sensor, counter and status signals of the client queue sequencer
interface client_queue_ctrl_if #(
  parameter int BITS    = 3,
  parameter int WT_BITS = 6
);
  logic               arrive_in;
  logic               serve_in;
  logic [BITS-1:0]    cnt_q;
  logic               cnt_up;
  logic               cnt_down;
  logic               full;
  logic               empty;
  logic               rej_arrive;
  logic               rej_serve;
  logic               lost_evt;
  logic               busy;
  logic [WT_BITS-1:0] wait_time;

  modport master (
    input  arrive_in, serve_in, cnt_q,
    output cnt_up, cnt_down, full, empty, rej_arrive, rej_serve, lost_evt, busy, wait_time
  );

  modport slave (
    output arrive_in, serve_in, cnt_q,
    input  cnt_up, cnt_down, full, empty, rej_arrive, rej_serve, lost_evt, busy, wait_time
  );
endinterface

// File: rtl/client_queue_ctrl_sync_edge_det.sv
// rtl/client_queue_ctrl_sync_edge_det.sv - two-flop synchronizer with rising-edge pulse
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_pulse
);
  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~prev;
endmodule

// File: rtl/client_queue_ctrl.sv
// rtl/client_queue_ctrl.sv - turns arrival/service events into guarded up/down counter strobes
module client_queue_ctrl
  import client_queue_pkg::*;
#(
  parameter int BITS        = 3,
  parameter int MAX_CLIENTS = DEF_MAX_CLIENTS,
  parameter int SVC_TIME    = DEF_SVC_TIME,
  parameter int WT_BITS     = min_wt_bits(DEF_MAX_CLIENTS, DEF_SVC_TIME)
) (
  input logic                 clk,
  input logic                 reset_n,
  client_queue_ctrl_if.master bus
);
  localparam logic [BITS-1:0]    MAX_Q = BITS'(MAX_CLIENTS);
  localparam logic [WT_BITS-1:0] SVC_W = WT_BITS'(SVC_TIME);

  state_t state, state_nx;
  logic   arr_edge, srv_edge;
  logic   pend_arr, pend_srv;
  logic   take_arr, take_srv;
  logic   up_nx, down_nx, rej_arr_nx, rej_srv_nx;
  logic   at_top, at_zero;

  sync_edge_det u_arr (.clk(clk), .reset_n(reset_n), .async_in(bus.arrive_in), .edge_pulse(arr_edge));
  sync_edge_det u_srv (.clk(clk), .reset_n(reset_n), .async_in(bus.serve_in),  .edge_pulse(srv_edge));

  // Decisions treat any value at or above the ceiling as full so the counter can never wrap.
  assign at_top    = (bus.cnt_q >= MAX_Q);
  assign at_zero   = (bus.cnt_q == '0);
  assign bus.full  = (bus.cnt_q == MAX_Q);
  assign bus.empty = at_zero;
  assign bus.busy  = (state != IDLE);

  always_comb begin
    state_nx   = state;
    take_arr   = 1'b0;
    take_srv   = 1'b0;
    up_nx      = 1'b0;
    down_nx    = 1'b0;
    rej_arr_nx = 1'b0;
    rej_srv_nx = 1'b0;
    case (state)
      IDLE: begin
        if (pend_arr && pend_srv) begin
          // At a boundary only the legal direction goes first; the other flag waits its turn.
          if (at_zero) begin
            take_arr = 1'b1;
            up_nx    = 1'b1;
            state_nx = ISSUE;
          end else if (at_top) begin
            take_srv = 1'b1;
            down_nx  = 1'b1;
            state_nx = ISSUE;
          end else begin
            take_arr = 1'b1;
            take_srv = 1'b1;
          end
        end else if (pend_arr) begin
          take_arr = 1'b1;
          if (!at_top) begin
            up_nx    = 1'b1;
            state_nx = ISSUE;
          end else begin
            rej_arr_nx = 1'b1;
          end
        end else if (pend_srv) begin
          take_srv = 1'b1;
          if (!at_zero) begin
            down_nx  = 1'b1;
            state_nx = ISSUE;
          end else begin
            rej_srv_nx = 1'b1;
          end
        end
      end
      ISSUE:   state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      pend_arr       <= 1'b0;
      pend_srv       <= 1'b0;
      bus.cnt_up     <= 1'b0;
      bus.cnt_down   <= 1'b0;
      bus.rej_arrive <= 1'b0;
      bus.rej_serve  <= 1'b0;
      bus.lost_evt   <= 1'b0;
      bus.wait_time  <= '0;
    end else begin
      state          <= state_nx;
      pend_arr       <= (pend_arr & ~take_arr) | arr_edge;
      pend_srv       <= (pend_srv & ~take_srv) | srv_edge;
      bus.cnt_up     <= up_nx;
      bus.cnt_down   <= down_nx;
      bus.rej_arrive <= rej_arr_nx;
      bus.rej_serve  <= rej_srv_nx;
      bus.lost_evt   <= (arr_edge & pend_arr & ~take_arr) | (srv_edge & pend_srv & ~take_srv);
      bus.wait_time  <= WT_BITS'(bus.cnt_q) * SVC_W;
    end
  end
endmodule

// File: tb/tb_client_queue_ctrl.sv
// tb/tb_client_queue_ctrl.sv - self-checking bench for client_queue_ctrl
module tb_client_queue_ctrl;
  localparam int BITS = 3;
  localparam int MAXC = 7;
  localparam int SVC  = 5;
  localparam int WTB  = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b1;
  logic [2:0] load_val = 3'd0;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int n_up = 0, n_down = 0, n_rja = 0, n_rjs = 0, n_lost = 0, n_viol = 0;
  int up_cyc = 0, down_cyc = 0;
  logic prev_up = 1'b0, prev_down = 1'b0;

  always #5 clk = ~clk;

  client_queue_ctrl_if #(.BITS(BITS), .WT_BITS(WTB)) bus ();

  client_queue_ctrl #(.BITS(BITS), .MAX_CLIENTS(MAXC), .SVC_TIME(SVC), .WT_BITS(WTB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // External occupancy counter driven by the strobes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) bus.cnt_q <= load_val;
    else if (bus.cnt_up && !bus.cnt_down) bus.cnt_q <= bus.cnt_q + 3'd1;
    else if (bus.cnt_down && !bus.cnt_up) bus.cnt_q <= bus.cnt_q - 3'd1;
  end

  always @(negedge clk) begin
    if (bus.cnt_up) begin n_up <= n_up + 1; up_cyc <= cyc; end
    if (bus.cnt_down) begin n_down <= n_down + 1; down_cyc <= cyc; end
    if (bus.rej_arrive) n_rja <= n_rja + 1;
    if (bus.rej_serve) n_rjs <= n_rjs + 1;
    if (bus.lost_evt) n_lost <= n_lost + 1;
    if ((bus.cnt_up && bus.cnt_down) || (bus.cnt_up && prev_up) || (bus.cnt_down && prev_down))
      n_viol <= n_viol + 1;
    prev_up   <= bus.cnt_up;
    prev_down <= bus.cnt_down;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.arrive_in = 1'b0; bus.serve_in = 1'b0; load = 1'b1; load_val = 3'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; load = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input logic [2:0] v);
    @(negedge clk); load = 1'b1; load_val = v;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic s, input int gap);
    @(negedge clk); bus.arrive_in = a; bus.serve_in = s;
    repeat (2) @(negedge clk);
    bus.arrive_in = 1'b0; bus.serve_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; bus.arrive_in = 1'b0; bus.serve_in = 1'b0; load = 1'b1; load_val = 3'd0;
    repeat (2) @(negedge clk);
    total++; if ({bus.cnt_up, bus.cnt_down, bus.rej_arrive, bus.rej_serve, bus.lost_evt, bus.busy} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000", {bus.cnt_up, bus.cnt_down, bus.rej_arrive, bus.rej_serve, bus.lost_evt, bus.busy}); else passed++;
    total++; if (bus.wait_time !== 6'd0) $display("FAIL reset_wait_time: got %0d expected 0", bus.wait_time); else passed++;
    total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("FAIL reset_empty_full: got %b%b expected 10", bus.empty, bus.full); else passed++;
    reset_n = 1'b1; load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_arrival();
    int c0, u0;
    do_reset();
    u0 = n_up; c0 = cyc;
    bus.arrive_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.arrive_in = 1'b0;
    @(negedge clk);
    total++; if (bus.cnt_up !== 1'b0) $display("FAIL single_early_up: got %b expected 0 at +%0d", bus.cnt_up, cyc - c0); else passed++;
    @(negedge clk);
    total++; if (bus.cnt_up !== 1'b1) $display("FAIL single_up_latency: got %b expected 1 at +%0d", bus.cnt_up, cyc - c0); else passed++;
    @(negedge clk);
    total++; if (bus.cnt_q !== 3'd1 || bus.busy !== 1'b1 || bus.cnt_up !== 1'b0)
      $display("FAIL single_settle: got cnt=%0d busy=%b up=%b expected cnt=1 busy=1 up=0", bus.cnt_q, bus.busy, bus.cnt_up); else passed++;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL single_busy_done: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.wait_time !== 6'd5) $display("FAIL single_wait_time: got %0d expected 5", bus.wait_time); else passed++;
    total++; if (bus.empty !== 1'b0) $display("FAIL single_empty: got %b expected 0", bus.empty); else passed++;
    repeat (4) @(negedge clk);
    total++; if (n_up - u0 !== 1) $display("FAIL single_up_count: got %0d expected 1", n_up - u0); else passed++;
  endtask

  task automatic test_fill();
    int u0, r0, d0;
    do_reset();
    u0 = n_up; r0 = n_rja; d0 = n_down;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 10);
    total++; if (n_up - u0 !== 7) $display("FAIL fill_up_count: got %0d expected 7", n_up - u0); else passed++;
    total++; if (n_rja - r0 !== 1) $display("FAIL fill_rej_arrive: got %0d expected 1", n_rja - r0); else passed++;
    total++; if (n_down - d0 !== 0) $display("FAIL fill_down_count: got %0d expected 0", n_down - d0); else passed++;
    total++; if (bus.cnt_q !== 3'd7 || bus.full !== 1'b1) $display("FAIL fill_full: got cnt=%0d full=%b expected 7/1", bus.cnt_q, bus.full); else passed++;
    total++; if (bus.wait_time !== 6'd35) $display("FAIL fill_wait_time: got %0d expected 35", bus.wait_time); else passed++;
  endtask

  task automatic test_underflow();
    int d0, r0;
    preload(3'd0);
    d0 = n_down; r0 = n_rjs;
    drive(1'b0, 1'b1, 10);
    total++; if (n_rjs - r0 !== 1) $display("FAIL under_rej_serve: got %0d expected 1", n_rjs - r0); else passed++;
    total++; if (n_down - d0 !== 0) $display("FAIL under_down: got %0d expected 0", n_down - d0); else passed++;
    total++; if (bus.cnt_q !== 3'd0 || bus.empty !== 1'b1) $display("FAIL under_cnt: got cnt=%0d empty=%b expected 0/1", bus.cnt_q, bus.empty); else passed++;
  endtask

  task automatic test_simultaneous();
    int u0, d0;
    preload(3'd3);
    u0 = n_up; d0 = n_down;
    drive(1'b1, 1'b1, 14);
    total++; if (n_up - u0 !== 0 || n_down - d0 !== 0) $display("FAIL simul_mid_strobes: got up=%0d down=%0d expected 0/0", n_up - u0, n_down - d0); else passed++;
    total++; if (bus.cnt_q !== 3'd3 || bus.busy !== 1'b0) $display("FAIL simul_mid_cnt: got cnt=%0d busy=%b expected 3/0", bus.cnt_q, bus.busy); else passed++;
    preload(3'd0);
    u0 = n_up; d0 = n_down;
    drive(1'b1, 1'b1, 14);
    total++; if (n_up - u0 !== 1 || n_down - d0 !== 1) $display("FAIL simul_zero_strobes: got up=%0d down=%0d expected 1/1", n_up - u0, n_down - d0); else passed++;
    total++; if (down_cyc - up_cyc !== 3) $display("FAIL simul_zero_order: got spacing %0d expected 3", down_cyc - up_cyc); else passed++;
    total++; if (bus.cnt_q !== 3'd0) $display("FAIL simul_zero_cnt: got %0d expected 0", bus.cnt_q); else passed++;
    preload(3'd7);
    u0 = n_up; d0 = n_down;
    drive(1'b1, 1'b1, 14);
    total++; if (n_up - u0 !== 1 || n_down - d0 !== 1) $display("FAIL simul_max_strobes: got up=%0d down=%0d expected 1/1", n_up - u0, n_down - d0); else passed++;
    total++; if (up_cyc - down_cyc !== 3) $display("FAIL simul_max_order: got spacing %0d expected 3", up_cyc - down_cyc); else passed++;
    total++; if (bus.cnt_q !== 3'd7) $display("FAIL simul_max_cnt: got %0d expected 7", bus.cnt_q); else passed++;
  endtask

  task automatic test_back_to_back();
    int u0, l0;
    preload(3'd2);
    u0 = n_up; l0 = n_lost;
    @(negedge clk); bus.arrive_in = 1'b1;
    @(negedge clk); bus.arrive_in = 1'b0;
    @(negedge clk); bus.arrive_in = 1'b1;
    @(negedge clk); bus.arrive_in = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (n_up - u0 !== 2 || n_lost - l0 !== 0) $display("FAIL b2b_accept: got up=%0d lost=%0d expected 2/0", n_up - u0, n_lost - l0); else passed++;
    total++; if (bus.cnt_q !== 3'd4) $display("FAIL b2b_cnt: got %0d expected 4", bus.cnt_q); else passed++;
  endtask

  task automatic test_lost_event();
    int u0, d0, l0;
    preload(3'd7);
    u0 = n_up; d0 = n_down; l0 = n_lost;
    // Arrival stays pending behind the service at the ceiling, so a second arrival edge is dropped.
    @(negedge clk); bus.arrive_in = 1'b1; bus.serve_in = 1'b1;
    @(negedge clk); bus.arrive_in = 1'b0; bus.serve_in = 1'b0;
    @(negedge clk); bus.arrive_in = 1'b1;
    @(negedge clk); bus.arrive_in = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (n_lost - l0 !== 1) $display("FAIL lost_pulse: got %0d expected 1", n_lost - l0); else passed++;
    total++; if (n_up - u0 !== 1 || n_down - d0 !== 1) $display("FAIL lost_strobes: got up=%0d down=%0d expected 1/1", n_up - u0, n_down - d0); else passed++;
    total++; if (bus.cnt_q !== 3'd7) $display("FAIL lost_cnt: got %0d expected 7", bus.cnt_q); else passed++;
  endtask

  task automatic test_reset_mid();
    int u0;
    do_reset();
    u0 = n_up;
    bus.arrive_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.arrive_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if ({bus.cnt_up, bus.cnt_down, bus.rej_arrive, bus.rej_serve, bus.lost_evt, bus.busy} !== 6'b0)
      $display("FAIL midreset_outputs: got %b expected 000000", {bus.cnt_up, bus.cnt_down, bus.rej_arrive, bus.rej_serve, bus.lost_evt, bus.busy}); else passed++;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (n_up - u0 !== 0 || bus.cnt_q !== 3'd0) $display("FAIL midreset_abort: got up=%0d cnt=%0d expected 0/0", n_up - u0, bus.cnt_q); else passed++;
    drive(1'b1, 1'b0, 10);
    total++; if (n_up - u0 !== 1 || bus.cnt_q !== 3'd1) $display("FAIL midreset_recover: got up=%0d cnt=%0d expected 1/1", n_up - u0, bus.cnt_q); else passed++;
  endtask

  task automatic test_random();
    int c, u0, d0, ra0, rs0, l0, eu, ed, era, ers, t;
    logic a, s;
    c = $urandom_range(0, MAXC);
    preload(3'(c));
    u0 = n_up; d0 = n_down; ra0 = n_rja; rs0 = n_rjs; l0 = n_lost;
    eu = 0; ed = 0; era = 0; ers = 0;
    for (int i = 0; i < 24; i++) begin
      t = $urandom_range(0, 2);
      a = (t != 1);
      s = (t != 0);
      if (a && s) begin
        if (c == 0 || c == MAXC) begin eu++; ed++; end
      end else if (a) begin
        if (c < MAXC) begin c++; eu++; end else era++;
      end else begin
        if (c > 0) begin c--; ed++; end else ers++;
      end
      drive(a, s, 14);
      total++; if (bus.cnt_q !== 3'(c)) $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, bus.cnt_q, c); else passed++;
      total++; if (bus.wait_time !== 6'(c * SVC)) $display("FAIL rand_wait[%0d]: got %0d expected %0d", i, bus.wait_time, c * SVC); else passed++;
    end
    total++; if (n_up - u0 !== eu || n_down - d0 !== ed) $display("FAIL rand_strobes: got up=%0d down=%0d expected %0d/%0d", n_up - u0, n_down - d0, eu, ed); else passed++;
    total++; if (n_rja - ra0 !== era || n_rjs - rs0 !== ers) $display("FAIL rand_rejects: got %0d/%0d expected %0d/%0d", n_rja - ra0, n_rjs - rs0, era, ers); else passed++;
    total++; if (n_lost - l0 !== 0) $display("FAIL rand_lost: got %0d expected 0", n_lost - l0); else passed++;
  endtask

  task automatic test_invariants();
    total++; if (n_viol !== 0) $display("FAIL strobe_exclusive: got %0d violations expected 0", n_viol); else passed++;
  endtask

  initial begin
    bus.arrive_in = 1'b0;
    bus.serve_in  = 1'b0;
    test_reset();
    test_single_arrival();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    test_lost_event();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
